// File: rtl/rst_pkg.sv
// Shared types and reset-cause encodings for the reset sequencer and its helpers.
package rst_pkg;

    typedef enum logic [1:0] {
        HOLD,
        STRETCH,
        RELEASE,
        RUN
    } rst_state_t;

    typedef logic [1:0] rst_cause_t;

    localparam rst_cause_t CAUSE_NONE = 2'b00;
    localparam rst_cause_t CAUSE_POR  = 2'b01;
    localparam rst_cause_t CAUSE_SW   = 2'b10;
    localparam rst_cause_t CAUSE_WDT  = 2'b11;

endpackage

// File: rtl/reset_sequencer_if.sv
// Warm-reset request inputs and sequenced reset outputs of the reset sequencer.
interface reset_sequencer_if
    import rst_pkg::*;
#(
    parameter int N_RST = 3
);
    logic             SW_RST_REQ;
    logic             WDT_RST_REQ;
    logic             CAUSE_CLR;
    logic [N_RST-1:0] RESETn_OUT;
    logic             READY;
    rst_cause_t       RST_CAUSE;

    // Requester side: raises reset requests and observes the sequenced resets.
    modport master (
        output SW_RST_REQ, WDT_RST_REQ, CAUSE_CLR,
        input  RESETn_OUT, READY, RST_CAUSE
    );

    modport slave (
        input  SW_RST_REQ, WDT_RST_REQ, CAUSE_CLR,
        output RESETn_OUT, READY, RST_CAUSE
    );
endinterface

// File: rtl/rst_sync.sv
// Asynchronous-assert, synchronous-deassert reset synchroniser; reusable for any clock domain.
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic ASYNC_RSTn,
    output logic SYNC_RSTn
);
    logic [STAGES-1:0] chain_q;

    // NOTE: flops take non-blocking assignments so every stage samples the previous stage's old value.
    always_ff @(posedge CLK or negedge ASYNC_RSTn) begin
        if (!ASYNC_RSTn) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], 1'b1};
        end
    end

    assign SYNC_RSTn = chain_q[STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// Power-on reset stretcher and ordered release of subsystem resets, with warm reset and sticky cause.
module reset_sequencer
    import rst_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int N_RST          = 3,
    parameter int STRETCH_CYCLES = 16,
    parameter int GAP_CYCLES     = 4
) (
    input  logic              CLK,
    input  logic              PORESETn,
    reset_sequencer_if.slave  bus
);
    localparam int MAX_CYC = (STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = $clog2(N_RST + 1);

    logic             por_ok;
    logic             warm_req;
    rst_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_RST-1:0] out_q, out_d;
    logic             ready_q, ready_d;
    rst_cause_t       cause_q, cause_d;

    rst_sync #(.STAGES(SYNC_STAGES)) u_por_sync (
        .CLK        (CLK),
        .ASYNC_RSTn (PORESETn),
        .SYNC_RSTn  (por_ok)
    );

    assign warm_req = bus.SW_RST_REQ | bus.WDT_RST_REQ;

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        out_d   = out_q;
        ready_d = ready_q;
        cause_d = cause_q;

        if (state_q != HOLD && bus.CAUSE_CLR) begin
            cause_d = CAUSE_NONE;
        end

        case (state_q)
            HOLD: begin
                if (por_ok) begin
                    state_d = STRETCH;
                    cnt_d   = '0;
                end
            end
            STRETCH: begin
                if (cnt_q == CNT_W'(STRETCH_CYCLES - 1)) begin
                    cnt_d    = '0;
                    out_d[0] = 1'b1;
                    if (N_RST == 1) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = RELEASE;
                        idx_d   = IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    idx_d = idx_q + 1'b1;
                    for (int i = 0; i < N_RST; i++) begin
                        if (i == int'(idx_q)) out_d[i] = 1'b1;
                    end
                    // The last release and READY land on the same edge.
                    if (int'(idx_q) == N_RST - 1) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN:     ;
            default: state_d = HOLD;
        endcase

        // Warm reset overrides normal progression and any cause clear in the same cycle.
        if (state_q != HOLD && warm_req) begin
            state_d = STRETCH;
            cnt_d   = '0;
            idx_d   = '0;
            out_d   = '0;
            ready_d = 1'b0;
            cause_d = bus.WDT_RST_REQ ? CAUSE_WDT : CAUSE_SW;
        end
    end

    always_ff @(posedge CLK or negedge PORESETn) begin
        if (!PORESETn) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
            cause_q <= CAUSE_POR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            cause_q <= cause_d;
        end
    end

    assign bus.RESETn_OUT = out_q;
    assign bus.READY      = ready_q;
    assign bus.RST_CAUSE  = cause_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance plus a minimal (N_RST=1, 1-cycle) instance, both against a timing model.
module tb_reset_sequencer;
    import rst_pkg::*;

    logic CLK = 1'b0;
    logic PORESETn = 1'b1;
    logic sw = 1'b0, wdt = 1'b0, clr = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    reset_sequencer_if #(.N_RST(3)) bus_a ();
    reset_sequencer_if #(.N_RST(1)) bus_b ();

    assign bus_a.SW_RST_REQ  = sw;
    assign bus_a.WDT_RST_REQ = wdt;
    assign bus_a.CAUSE_CLR   = clr;
    assign bus_b.SW_RST_REQ  = sw;
    assign bus_b.WDT_RST_REQ = wdt;
    assign bus_b.CAUSE_CLR   = clr;

    reset_sequencer #(.SYNC_STAGES(2), .N_RST(3), .STRETCH_CYCLES(16), .GAP_CYCLES(4)) dut_a (
        .CLK (CLK), .PORESETn (PORESETn), .bus (bus_a.slave)
    );
    reset_sequencer #(.SYNC_STAGES(3), .N_RST(1), .STRETCH_CYCLES(1), .GAP_CYCLES(1)) dut_b (
        .CLK (CLK), .PORESETn (PORESETn), .bus (bus_b.slave)
    );

    logic [2:0] outv   [2];
    logic       readyv [2];
    logic [1:0] causev [2];
    assign outv[0]   = bus_a.RESETn_OUT;
    assign outv[1]   = {2'b00, bus_b.RESETn_OUT};
    assign readyv[0] = bus_a.READY;
    assign readyv[1] = bus_b.READY;
    assign causev[0] = bus_a.RST_CAUSE;
    assign causev[1] = bus_b.RST_CAUSE;

    // Per-instance parameters seen by the model.
    int p_sync [2] = '{2, 3};
    int p_n    [2] = '{3, 1};
    int p_str  [2] = '{16, 1};
    int p_gap  [2] = '{4, 1};

    // Model: an instance is either waiting for power-on, or counting edges since its last stretch start t0.
    int         ecnt = 0;
    bit         in_hold [2] = '{1'b1, 1'b1};
    int         syncc   [2] = '{0, 0};
    int         t0      [2] = '{0, 0};
    logic [1:0] cause_m [2] = '{CAUSE_POR, CAUSE_POR};

    always @(posedge CLK or negedge PORESETn) begin
        if (!PORESETn) begin
            for (int i = 0; i < 2; i++) begin
                in_hold[i] = 1'b1;
                syncc[i]   = 0;
                cause_m[i] = CAUSE_POR;
            end
        end else begin
            ecnt++;
            for (int i = 0; i < 2; i++) begin
                if (in_hold[i]) begin
                    syncc[i]++;
                    if (syncc[i] == p_sync[i] + 1) begin
                        in_hold[i] = 1'b0;
                        t0[i]      = ecnt;
                    end
                end else if (wdt) begin
                    t0[i] = ecnt; cause_m[i] = CAUSE_WDT;
                end else if (sw) begin
                    t0[i] = ecnt; cause_m[i] = CAUSE_SW;
                end else if (clr) begin
                    cause_m[i] = CAUSE_NONE;
                end
            end
        end
    end

    function automatic logic [2:0] exp_out(int i);
        logic [2:0] v = '0;
        if (!in_hold[i]) begin
            for (int b = 0; b < p_n[i]; b++) begin
                if (ecnt - t0[i] >= p_str[i] + b * p_gap[i]) v[b] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic exp_ready(int i);
        return !in_hold[i] && (ecnt - t0[i] >= p_str[i] + (p_n[i] - 1) * p_gap[i]);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("cmp%0d_out", i),   8'(outv[i]),   8'(exp_out(i)));
            check($sformatf("cmp%0d_ready", i), 8'(readyv[i]), 8'(exp_ready(i)));
            check($sformatf("cmp%0d_cause", i), 8'(causev[i]), 8'(cause_m[i]));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    int por_low = 0;
    int wdt_hold = 0;

    initial begin
        #1 PORESETn = 1'b0;
        #2;
        check("rst_out_a",   8'(outv[0]),   8'h0);
        check("rst_ready_a", 8'(readyv[0]), 8'h0);
        check("rst_cause_a", 8'(causev[0]), 8'h1);
        check("rst_out_b",   8'(outv[1]),   8'h0);

        // Power-on release between edges; edge 1 is the next rising edge.
        repeat (3) tick();
        #1 PORESETn = 1'b1;
        for (int e = 1; e <= 27; e++) begin
            tick();
            if (e == 4)  check("por_b_ready4",  8'(readyv[1]), 8'h0);
            if (e == 5)  check("por_b_out5",    8'(outv[1]),   8'h1);
            if (e == 5)  check("por_b_ready5",  8'(readyv[1]), 8'h1);
            if (e == 18) check("por_a_out18",   8'(outv[0]),   8'h0);
            if (e == 19) check("por_a_out19",   8'(outv[0]),   8'h1);
            if (e == 22) check("por_a_out22",   8'(outv[0]),   8'h1);
            if (e == 23) check("por_a_out23",   8'(outv[0]),   8'h3);
            if (e == 26) check("por_a_ready26", 8'(readyv[0]), 8'h0);
            if (e == 27) check("por_a_out27",   8'(outv[0]),   8'h7);
            if (e == 27) check("por_a_ready27", 8'(readyv[0]), 8'h1);
            if (e == 27) check("por_a_cause",   8'(causev[0]), 8'h1);
        end

        // Software warm reset from RUN.
        repeat (12) tick();
        #1 sw = 1'b1;
        tick();
        check("sw_out",   8'(outv[0]),   8'h0);
        check("sw_ready", 8'(readyv[0]), 8'h0);
        check("sw_cause", 8'(causev[0]), 8'h2);
        #1 sw = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            tick();
            if (e == 15) check("sw_out15", 8'(outv[0]), 8'h0);
            if (e == 16) check("sw_out16", 8'(outv[0]), 8'h1);
            if (e == 20) check("sw_out20", 8'(outv[0]), 8'h3);
            if (e == 24) check("sw_out24", 8'(outv[0]), 8'h7);
        end

        // Simultaneous SW, WDT and clear: watchdog cause wins.
        repeat (5) tick();
        #1 begin sw = 1'b1; wdt = 1'b1; clr = 1'b1; end
        tick();
        check("both_cause_a", 8'(causev[0]), 8'h3);
        check("both_cause_b", 8'(causev[1]), 8'h3);
        #1 begin sw = 1'b0; wdt = 1'b0; clr = 1'b0; end

        // Cause clear in RUN.
        repeat (30) tick();
        #1 clr = 1'b1;
        tick();
        check("clr_cause_a", 8'(causev[0]), 8'h0);
        check("clr_cause_b", 8'(causev[1]), 8'h0);
        #1 clr = 1'b0;

        // Watchdog pulse while only bit 0 is released.
        #1 sw = 1'b1;
        tick();
        #1 sw = 1'b0;
        repeat (17) tick();
        check("wdt_pre_out", 8'(outv[0]), 8'h1);
        #1 wdt = 1'b1;
        tick();
        check("wdt_out",   8'(outv[0]),   8'h0);
        check("wdt_cause", 8'(causev[0]), 8'h3);
        #1 wdt = 1'b0;
        repeat (15) tick();
        check("wdt_out15", 8'(outv[0]), 8'h0);
        tick();
        check("wdt_out16", 8'(outv[0]), 8'h1);

        // Power-on reset asserted between edges during STRETCH.
        #1 sw = 1'b1;
        tick();
        #1 sw = 1'b0;
        repeat (5) tick();
        #2 PORESETn = 1'b0;
        #1;
        check("async_out",   8'(outv[0]),   8'h0);
        check("async_ready", 8'(readyv[0]), 8'h0);
        check("async_cause", 8'(causev[0]), 8'h1);
        repeat (3) tick();
        #1 PORESETn = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            tick();
            if (e == 18) check("repor_out18", 8'(outv[0]), 8'h0);
            if (e == 19) check("repor_out19", 8'(outv[0]), 8'h1);
        end

        // Random requests, clears and occasional power-on pulses against the model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            #1;
            sw  = ($urandom_range(0, 59) == 0);
            clr = ($urandom_range(0, 39) == 0);
            if (wdt_hold > 0) begin
                wdt_hold--;
            end else if ($urandom_range(0, 79) == 0) begin
                wdt_hold = $urandom_range(0, 5);
            end
            wdt = (wdt_hold > 0) || ($urandom_range(0, 99) == 0);
            if (por_low > 0) begin
                por_low--;
                if (por_low == 0) PORESETn = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                por_low  = $urandom_range(1, 4);
                PORESETn = 1'b0;
            end
        end
        #1 begin sw = 1'b0; wdt = 1'b0; clr = 1'b0; PORESETn = 1'b1; end
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
